// File: rtl/mdu_ctrl_if.sv
// Handshake bundle between the E-stage datapath/hazard unit and the multiply/divide controller.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] A;
  logic [31:0] B;
  logic        usehiloD;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        stall;

  modport master (
    output start, mdop, A, B, usehiloD,
    input  HI, LO, busy, stall
  );

  modport slave (
    input  start, mdop, A, B, usehiloD,
    output HI, LO, busy, stall
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, times multi-cycle ops and raises the D-stage HI/LO-use stall.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  mdu_ctrl_if.slave  bus
);

  localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW        = $clog2(MaxCycles + 1);

  typedef enum logic [2:0] {
    OpNop   = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpDiv   = 3'd3,
    OpDivu  = 3'd4,
    OpMthi  = 3'd5,
    OpMtlo  = 3'd6,
    OpNop7  = 3'd7
  } mdOpT;

  typedef enum logic {Idle, Busy} stateT;

  stateT         state, stateNext;
  logic [CW-1:0] count, countNext;
  logic [31:0]   hiReg, hiNext, loReg, loNext;
  logic [31:0]   tHi, tHiNext, tLo, tLoNext;
  logic          tWrite, tWriteNext;

  logic [31:0]        resHi, resLo;
  logic               resWrite;
  logic               isMdOp;
  logic signed [63:0] prodS;
  logic [63:0]        prodU;
  logic signed [31:0] quotS, remS;

  assign isMdOp = (bus.mdop >= 3'd1) && (bus.mdop <= 3'd4);

  // Result is formed from the E-stage operands in the issue cycle; the busy period only models latency.
  // The most-negative/-1 divide is special-cased so it wraps instead of overflowing.
  always_comb begin
    resHi    = '0;
    resLo    = '0;
    resWrite = 1'b1;
    prodS    = '0;
    prodU    = '0;
    quotS    = '0;
    remS     = '0;
    case (mdOpT'(bus.mdop))
      OpMult: begin
        prodS = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
        resHi = prodS[63:32];
        resLo = prodS[31:0];
      end
      OpMultu: begin
        prodU = {32'd0, bus.A} * {32'd0, bus.B};
        resHi = prodU[63:32];
        resLo = prodU[31:0];
      end
      OpDiv: begin
        if (bus.B == 32'd0) begin
          resWrite = 1'b0;
        end else if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
          resLo = 32'h8000_0000;
          resHi = 32'd0;
        end else begin
          quotS = $signed(bus.A) / $signed(bus.B);
          remS  = $signed(bus.A) % $signed(bus.B);
          resLo = quotS;
          resHi = remS;
        end
      end
      OpDivu: begin
        if (bus.B == 32'd0) begin
          resWrite = 1'b0;
        end else begin
          resLo = bus.A / bus.B;
          resHi = bus.A % bus.B;
        end
      end
      default: ;
    endcase
  end

  // Next-state logic; anything that starts while Busy is dropped because the hazard unit never issues it.
  always_comb begin
    stateNext  = state;
    countNext  = count;
    hiNext     = hiReg;
    loNext     = loReg;
    tHiNext    = tHi;
    tLoNext    = tLo;
    tWriteNext = tWrite;
    case (state)
      Idle: begin
        if (bus.start) begin
          case (mdOpT'(bus.mdop))
            OpMult, OpMultu, OpDiv, OpDivu: begin
              tHiNext    = resHi;
              tLoNext    = resLo;
              tWriteNext = resWrite;
              countNext  = (bus.mdop <= 3'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
              stateNext  = Busy;
            end
            OpMthi:  hiNext = bus.A;
            OpMtlo:  loNext = bus.A;
            default: ;
          endcase
        end
      end
      Busy: begin
        if (count == CW'(1)) begin
          if (tWrite) begin
            hiNext = tHi;
            loNext = tLo;
          end
          countNext = '0;
          stateNext = Idle;
        end else begin
          countNext = count - CW'(1);
        end
      end
      default: stateNext = Idle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= Idle;
      count  <= '0;
      hiReg  <= '0;
      loReg  <= '0;
      tHi    <= '0;
      tLo    <= '0;
      tWrite <= 1'b0;
    end else begin
      state  <= stateNext;
      count  <= countNext;
      hiReg  <= hiNext;
      loReg  <= loNext;
      tHi    <= tHiNext;
      tLo    <= tLoNext;
      tWrite <= tWriteNext;
    end
  end

  assign bus.HI    = hiReg;
  assign bus.LO    = loReg;
  assign bus.busy  = (state == Busy);
  assign bus.stall = bus.usehiloD & (bus.busy | (bus.start & isMdOp));

  noStartWhileBusy: assert property (@(posedge clk) disable iff (reset)
    !(state == Busy && bus.start));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: constant-vector table, reset corner case and random ops vs. a 64-bit arithmetic model.
module tb_mdu_ctrl;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;
  logic [31:0] modelHi;
  logic [31:0] modelLo;

  mdu_ctrl_if bus ();

  mdu_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        useD;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vecT;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Reference works on 64-bit integers straight from the instruction definitions.
  function automatic void refOp(input logic st, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] oldHi, input logic [31:0] oldLo,
                                output logic [31:0] newHi, output logic [31:0] newLo);
    longint          sa, sb, q, r, p;
    longint unsigned ua, ub, uq, ur, up;
    newHi = oldHi;
    newLo = oldLo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (st) begin
      case (op)
        3'd1: begin p = sa * sb; newHi = p[63:32]; newLo = p[31:0]; end
        3'd2: begin up = ua * ub; newHi = up[63:32]; newLo = up[31:0]; end
        3'd3: if (b != 0) begin q = sa / sb; r = sa - q * sb; newHi = r[31:0]; newLo = q[31:0]; end
        3'd4: if (b != 0) begin uq = ua / ub; ur = ua - uq * ub; newHi = ur[31:0]; newLo = uq[31:0]; end
        3'd5: newHi = a;
        3'd6: newLo = a;
        default: ;
      endcase
    end
  endfunction

  // Issue one E-stage op at a negedge and follow it through its whole latency.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic st, input logic useD);
    logic [31:0] newHi, newLo;
    logic        md;
    int          n;
    md = st && (op >= 3'd1) && (op <= 3'd4);
    n  = !md ? 0 : ((op <= 3'd2) ? 5 : 10);
    refOp(st, op, a, b, modelHi, modelLo, newHi, newLo);
    bus.start    = st;
    bus.mdop     = op;
    bus.A        = a;
    bus.B        = b;
    bus.usehiloD = useD;
    #1;
    checkOutput("stallIssue", 32'(bus.stall), 32'(useD & md));
    @(negedge clk);
    bus.start = 1'b0;
    bus.mdop  = 3'd0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    for (int i = 0; i < n; i++) begin
      checkOutput("busyHigh", 32'(bus.busy), 32'd1);
      checkOutput("stallBusy", 32'(bus.stall), 32'(useD));
      checkOutput("hiHold", bus.HI, modelHi);
      checkOutput("loHold", bus.LO, modelLo);
      @(negedge clk);
    end
    checkOutput("busyDone", 32'(bus.busy), 32'd0);
    checkOutput("stallDone", 32'(bus.stall), 32'd0);
    checkOutput("hiResult", bus.HI, newHi);
    checkOutput("loResult", bus.LO, newLo);
    modelHi = newHi;
    modelLo = newLo;
  endtask

  vecT vecs [12];

  initial begin
    checkCount   = 0;
    passCount    = 0;
    modelHi      = '0;
    modelLo      = '0;
    bus.start    = 1'b0;
    bus.mdop     = 3'd0;
    bus.A        = '0;
    bus.B        = '0;
    bus.usehiloD = 1'b0;
    reset        = 1'b1;

    vecs[0]  = '{3'd1, 32'hFFFF_FFFD, 32'd5,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1]  = '{3'd4, 32'd7,         32'd2,         1'b0, 32'd1,         32'd3};
    vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'd5, 32'h11,        32'd0,         1'b0, 32'h11,        32'hFFFF_FFFD};
    vecs[4]  = '{3'd6, 32'h22,        32'd0,         1'b0, 32'h11,        32'h22};
    vecs[5]  = '{3'd3, 32'd5,         32'd0,         1'b1, 32'h11,        32'h22};
    vecs[6]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000};
    vecs[7]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[8]  = '{3'd5, 32'h1234_5678, 32'd0,         1'b1, 32'h1234_5678, 32'h0000_0001};
    vecs[9]  = '{3'd6, 32'h9ABC_DEF0, 32'd0,         1'b1, 32'h1234_5678, 32'h9ABC_DEF0};
    vecs[10] = '{3'd0, 32'hDEAD_BEEF, 32'd1,         1'b1, 32'h1234_5678, 32'h9ABC_DEF0};
    vecs[11] = '{3'd7, 32'hDEAD_BEEF, 32'd1,         1'b0, 32'h1234_5678, 32'h9ABC_DEF0};

    @(negedge clk);
    checkOutput("resetHi", bus.HI, 32'd0);
    checkOutput("resetLo", bus.LO, 32'd0);
    checkOutput("resetBusy", 32'(bus.busy), 32'd0);
    checkOutput("resetStall", 32'(bus.stall), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].op, vecs[v].a, vecs[v].b, 1'b1, vecs[v].useD);
      checkOutput($sformatf("vecHi%0d", v), bus.HI, vecs[v].expHi);
      checkOutput($sformatf("vecLo%0d", v), bus.LO, vecs[v].expLo);
    end

    // Reset landing in the third busy cycle of a multu must discard the pending result.
    bus.start = 1'b1;
    bus.mdop  = 3'd2;
    bus.A     = 32'hFFFF_FFFF;
    bus.B     = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mdop  = 3'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midResetHi", bus.HI, 32'd0);
    checkOutput("midResetLo", bus.LO, 32'd0);
    checkOutput("midResetBusy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("postResetBusy", 32'(bus.busy), 32'd0);
      checkOutput("postResetLo", bus.LO, 32'd0);
      @(negedge clk);
    end
    modelHi = '0;
    modelLo = '0;
    applyStimulus(3'd1, 32'd2, 32'd3, 1'b1, 1'b0);
    checkOutput("afterResetHi", bus.HI, 32'd0);
    checkOutput("afterResetLo", bus.LO, 32'd6);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 9);
      applyStimulus(3'($urandom_range(0, 7)), ra, rb, ($urandom_range(0, 7) != 0), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
